// File: rtl/button_event_if.sv
// Event bus between a debounced button level and the logic that reacts to key actions.
// The master drives the level and the slave (button_event) returns registered event pulses.
interface button_event_if;
   logic in;
   logic press;
   logic release_evt;
   logic long_press;
   logic repeat_evt;
   logic held;

   modport master (
      output in,
      input  press,
      input  release_evt,
      input  long_press,
      input  repeat_evt,
      input  held
   );

   modport slave (
      input  in,
      output press,
      output release_evt,
      output long_press,
      output repeat_evt,
      output held
   );
endinterface

// File: rtl/button_event.sv
// Converts a debounced button level into one-cycle press/release/long-press/repeat pulses
// plus a registered held level; every output comes straight from a flop.
module button_event #(
   parameter int HOLD_CYCLES   = 50_000_000,
   parameter int REPEAT_CYCLES = 10_000_000,
   parameter int CNT_WIDTH     = 26
) (
   input  logic           clk,
   input  logic           async_reset,
   button_event_if.slave  bus
);

   localparam longint MAX_CYCLES = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;

   if (HOLD_CYCLES < 2) begin : g_bad_hold
      $error("button_event: HOLD_CYCLES must be at least 2");
   end
   if (REPEAT_CYCLES < 2) begin : g_bad_repeat
      $error("button_event: REPEAT_CYCLES must be at least 2");
   end
   if ((MAX_CYCLES - 1) >= (64'sd1 <<< CNT_WIDTH)) begin : g_bad_width
      $error("button_event: CNT_WIDTH too small for max(HOLD_CYCLES, REPEAT_CYCLES)-1");
   end

   localparam logic [CNT_WIDTH-1:0] HOLD_LAST   = CNT_WIDTH'(HOLD_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] REPEAT_LAST = CNT_WIDTH'(REPEAT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      PRESSED,
      REPEATING
   } state_t;

   state_t               state_q, state_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                 press_q, press_d;
   logic                 release_q, release_d;
   logic                 long_press_q, long_press_d;
   logic                 repeat_q, repeat_d;
   logic                 held_q, held_d;

   // Release takes priority over a terminal count on the same edge.
   always_comb begin
      state_d      = state_q;
      cnt_d        = '0;
      press_d      = 1'b0;
      release_d    = 1'b0;
      long_press_d = 1'b0;
      repeat_d     = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (bus.in) begin
               state_d = PRESSED;
               press_d = 1'b1;
            end
         end
         PRESSED: begin
            if (!bus.in) begin
               state_d   = IDLE;
               release_d = 1'b1;
            end else if (cnt_q == HOLD_LAST) begin
               state_d      = REPEATING;
               long_press_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         REPEATING: begin
            if (!bus.in) begin
               state_d   = IDLE;
               release_d = 1'b1;
            end else if (cnt_q == REPEAT_LAST) begin
               repeat_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      held_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge async_reset) begin
      if (async_reset) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         press_q      <= 1'b0;
         release_q    <= 1'b0;
         long_press_q <= 1'b0;
         repeat_q     <= 1'b0;
         held_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         press_q      <= press_d;
         release_q    <= release_d;
         long_press_q <= long_press_d;
         repeat_q     <= repeat_d;
         held_q       <= held_d;
      end
   end

   assign bus.press       = press_q;
   assign bus.release_evt = release_q;
   assign bus.long_press  = long_press_q;
   assign bus.repeat_evt  = repeat_q;
   assign bus.held        = held_q;

endmodule

// File: tb/tb_button_event.sv
// Directed bench for button_event with HOLD_CYCLES=8, REPEAT_CYCLES=4; expected output
// vectors {press, release, long_press, repeat, held} are queued per step and compared after the edge.
module tb_button_event;

   logic clk = 1'b0;
   logic async_reset;

   always #5 clk = ~clk;

   button_event_if bif ();

   button_event #(
      .HOLD_CYCLES   (8),
      .REPEAT_CYCLES (4),
      .CNT_WIDTH     (4)
   ) dut (
      .clk         (clk),
      .async_reset (async_reset),
      .bus         (bif.slave)
   );

   typedef struct {
      logic [4:0] v;
      string      tag;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   localparam logic [4:0] O_IDLE = 5'b00000;
   localparam logic [4:0] O_HELD = 5'b00001;
   localparam logic [4:0] O_PRS  = 5'b10001;
   localparam logic [4:0] O_REL  = 5'b01000;
   localparam logic [4:0] O_LONG = 5'b00101;
   localparam logic [4:0] O_RPT  = 5'b00011;

   function automatic logic [4:0] outs();
      return {bif.press, bif.release_evt, bif.long_press, bif.repeat_evt, bif.held};
   endfunction

   task automatic expect_out(input logic [4:0] e, input string tag);
      exp_t x;
      x.v   = e;
      x.tag = tag;
      sb.push_back(x);
   endtask

   task automatic compare_head();
      exp_t       x;
      logic [4:0] obs;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $error("FAIL scoreboard_empty observed=%0d required=1", sb.size());
      end else begin
         x   = sb.pop_front();
         obs = outs();
         assert (obs === x.v) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", x.tag, obs, x.v);
         end
      end
   endtask

   task automatic step(input logic lvl, input logic [4:0] e, input string tag);
      bif.in = lvl;
      expect_out(e, tag);
      @(posedge clk);
      #1;
      compare_head();
   endtask

   initial begin
      logic [4:0] e;

      bif.in      = 1'b0;
      async_reset = 1'b1;
      #12;
      expect_out(O_IDLE, "reset_state");
      compare_head();
      @(negedge clk);
      async_reset = 1'b0;

      // Short press of three cycles.
      step(1'b1, O_PRS,  "t1_press");
      step(1'b1, O_HELD, "t1_held_a");
      step(1'b1, O_HELD, "t1_held_b");
      step(1'b0, O_REL,  "t1_release");
      step(1'b0, O_IDLE, "t1_idle");

      // Long hold with repeats.
      for (int t = 1; t <= 30; t++) begin
         if (t == 1)
            e = O_PRS;
         else if (t == 9)
            e = O_LONG;
         else if (t > 9 && ((t - 9) % 4 == 0))
            e = O_RPT;
         else
            e = O_HELD;
         step(1'b1, e, $sformatf("t2_hold_%0d", t));
      end
      step(1'b0, O_REL,  "t2_release");
      step(1'b0, O_IDLE, "t2_idle");

      // Release on the terminal-count edge: release wins over long_press.
      step(1'b1, O_PRS, "t3_press");
      for (int t = 2; t <= 8; t++) step(1'b1, O_HELD, $sformatf("t3_held_%0d", t));
      step(1'b0, O_REL,  "t3_release_wins");
      step(1'b0, O_IDLE, "t3_idle");

      // Asynchronous reset in REPEATING, then a held button counts as a new press.
      step(1'b1, O_PRS, "t4_press");
      for (int t = 2; t <= 8; t++) step(1'b1, O_HELD, $sformatf("t4_held_%0d", t));
      step(1'b1, O_LONG, "t4_long");
      step(1'b1, O_HELD, "t4_repeating");
      #2;
      async_reset = 1'b1;
      #1;
      expect_out(O_IDLE, "t4_async_clear");
      compare_head();
      @(negedge clk);
      async_reset = 1'b0;
      step(1'b1, O_PRS,  "t4_press_after_reset");
      step(1'b0, O_REL,  "t4_release");
      step(1'b0, O_IDLE, "t4_idle");

      // Rapid toggling: single-cycle presses.
      step(1'b1, O_PRS,  "t5_press_a");
      step(1'b0, O_REL,  "t5_release_a");
      step(1'b1, O_PRS,  "t5_press_b");
      step(1'b0, O_REL,  "t5_release_b");
      step(1'b0, O_IDLE, "t5_idle");

      // After the toggles the counter must have stayed at 0: a full hold times out exactly.
      step(1'b1, O_PRS, "t5_hold_press");
      for (int t = 2; t <= 8; t++) step(1'b1, O_HELD, $sformatf("t5_hold_%0d", t));
      step(1'b1, O_LONG, "t5_hold_long");
      step(1'b0, O_REL,  "t5_hold_release");

      checks++;
      assert (sb.size() == 0) else begin
         errors++;
         $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
